// File: rtl/mlp_pkg.sv
// Shared types and helpers for the MLP scoring datapath: state encoding, widths and saturation.
package mlp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIAS  = 3'd1,
        ST_MAC   = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int W_DEF      = 8;
    localparam int HRAW_W     = W_DEF + 5;
    localparam int ACC_W      = 2 * W_DEF + 8;
    localparam int SAT_CALC_W = 64;

    function automatic int hraw_w(input int w);
        return w + 5;
    endfunction

    function automatic int acc_w(input int w);
        return 2 * w + 8;
    endfunction

    // Clamp a sign-extended value into a signed field of width w; caller truncates to w bits.
    function automatic logic signed [SAT_CALC_W-1:0] sat_signed(
        input logic signed [SAT_CALC_W-1:0] v,
        input int unsigned                  w
    );
        logic signed [SAT_CALC_W-1:0] hi;
        logic signed [SAT_CALC_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/mlp_mac_unit.sv
// Signed multiply-accumulate: combinational product, registered accumulator with bias preload.
module mlp_mac_unit #(
    parameter int W  = 8,
    parameter int AW = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 acc_en,
    input  logic signed [AW-1:0] bias,
    input  logic signed [W-1:0]  a,
    input  logic signed [W-1:0]  b,
    output logic signed [AW-1:0] acc
);

    logic signed [2*W-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= bias;
        end else if (acc_en) begin
            acc <= acc + AW'(prod);
        end
    end

endmodule

// File: rtl/mlp_hidden_layer_seq.sv
// Hidden-layer engine: one time-multiplexed MAC walks N neurons x M inputs, saturating each score.
//  state | meaning
//  IDLE  | waiting for start; inputs latched on acceptance
//  BIAS  | preload accumulator with shifted bias of neuron i
//  MAC   | accumulate w[i][j]*x[j], j = 0..M-1
//  STORE | saturate neuron i into its buffer slot
//  DONE  | done pulse; h_raw_bus already holds the full new result
module mlp_hidden_layer_seq
    import mlp_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 8,
    parameter int M     = 9,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [M*W-1:0]         x_bus,
    input  logic [N*M*W-1:0]       w_h_bus,
    input  logic [N*W-1:0]         b_h_bus,
    output logic                   busy,
    output logic                   done,
    output logic [N*(W+5)-1:0]     h_raw_bus
);

    localparam int HW = hraw_w(W);
    localparam int AW = acc_w(W);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int JW = (M > 1) ? $clog2(M) : 1;

    state_t state;
    state_t state_nxt;

    logic [IW-1:0] i_idx;
    logic [JW-1:0] j_idx;
    logic          last_i;
    logic          last_j;

    logic signed [W-1:0]  x_r   [M];
    logic signed [W-1:0]  w_r   [N][M];
    logic signed [W-1:0]  b_r   [N];
    logic signed [HW-1:0] buf_r [N];

    logic                 load;
    logic                 acc_en;
    logic signed [AW-1:0] bias_ext;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sh;
    logic signed [HW-1:0] sat_val;

    assign last_i = (i_idx == IW'(N - 1));
    assign last_j = (j_idx == JW'(M - 1));

    assign bias_ext = signed'(AW'(b_r[i_idx])) <<< SHIFT;
    assign acc_sh   = acc >>> SHIFT;
    assign sat_val  = HW'(sat_signed(SAT_CALC_W'(acc_sh), HW));

    mlp_mac_unit #(
        .W  (W),
        .AW (AW)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .acc_en (acc_en),
        .bias   (bias_ext),
        .a      (w_r[i_idx][j_idx]),
        .b      (x_r[j_idx]),
        .acc    (acc)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        acc_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_BIAS;
                end
            end
            ST_BIAS: begin
                load      = 1'b1;
                state_nxt = ST_MAC;
            end
            ST_MAC: begin
                acc_en = 1'b1;
                if (last_j) begin
                    state_nxt = ST_STORE;
                end
            end
            ST_STORE: begin
                state_nxt = last_i ? ST_DONE : ST_BIAS;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            i_idx     <= '0;
            j_idx     <= '0;
            h_raw_bus <= '0;
            for (int k = 0; k < N; k++) begin
                buf_r[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        i_idx <= '0;
                        j_idx <= '0;
                    end
                end
                ST_BIAS: begin
                    j_idx <= '0;
                end
                ST_MAC: begin
                    if (!last_j) begin
                        j_idx <= j_idx + JW'(1);
                    end
                end
                ST_STORE: begin
                    buf_r[i_idx] <= sat_val;
                    if (last_i) begin
                        // Publish the whole vector on entry to DONE so it is valid while done is high.
                        for (int k = 0; k < N - 1; k++) begin
                            h_raw_bus[k*HW +: HW] <= buf_r[k];
                        end
                        h_raw_bus[(N-1)*HW +: HW] <= sat_val;
                    end else begin
                        i_idx <= i_idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Operand snapshot: only written on acceptance, so later bus changes cannot disturb a run.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            for (int j = 0; j < M; j++) begin
                x_r[j] <= x_bus[j*W +: W];
            end
            for (int i = 0; i < N; i++) begin
                b_r[i] <= b_h_bus[i*W +: W];
                for (int j = 0; j < M; j++) begin
                    w_r[i][j] <= w_h_bus[(i*M+j)*W +: W];
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_hidden_layer_seq.sv
// Directed bench for mlp_hidden_layer_seq: latency, arithmetic, saturation, latching, abort, throughput.
module tb_mlp_hidden_layer_seq;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int M  = 9;
    localparam int HW = W + 5;
    localparam int LAT = N * (M + 2) + 1;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [M*W-1:0]     x_bus;
    logic [N*M*W-1:0]   w_h_bus;
    logic [N*W-1:0]     b_h_bus;
    logic               busy;
    logic               done;
    logic [N*HW-1:0]    h_raw_bus;

    int tests_run;
    int tests_failed;

    mlp_hidden_layer_seq #(
        .W     (W),
        .N     (N),
        .M     (M),
        .SHIFT (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_bus     (x_bus),
        .w_h_bus   (w_h_bus),
        .b_h_bus   (b_h_bus),
        .busy      (busy),
        .done      (done),
        .h_raw_bus (h_raw_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [HW-1:0] h_at(input int i);
        return $signed(h_raw_bus[i*HW +: HW]);
    endfunction

    task automatic set_uniform(input int xv, input int wv, input int bv);
        for (int j = 0; j < M; j++) x_bus[j*W +: W] = W'(xv);
        for (int k = 0; k < N*M; k++) w_h_bus[k*W +: W] = W'(wv);
        for (int i = 0; i < N; i++) b_h_bus[i*W +: W] = W'(bv);
    endtask

    // Pulse start, then watch up to LAT+10 cycles; cycle 1 is the sample right after acceptance.
    task automatic do_run(output int done_cyc, output int ndone, output logic busy_c1);
        done_cyc = -1;
        ndone    = 0;
        busy_c1  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_c1 = busy;
        if (done) begin ndone++; done_cyc = 1; end
        for (int c = 2; c <= LAT + 10; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        set_uniform(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy=%b done=%b, want 0 0", busy, done);
        end
        tests_run++;
        if (h_raw_bus !== '0) begin
            tests_failed++;
            $display("FAIL reset_h: h_raw_bus=%h, want 0", h_raw_bus);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int dc, nd;
        logic b1;
        set_uniform(1, 1, 0);
        do_run(dc, nd, b1);
        tests_run++;
        if (b1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_busy: busy at cycle 1=%b, want 1", b1);
        end
        tests_run++;
        if (dc != 89 || nd != 1) begin
            tests_failed++;
            $display("FAIL basic_latency: done at %0d count %0d, want 89 count 1", dc, nd);
        end
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (h_at(i) !== 13'sd9) begin
                tests_failed++;
                $display("FAIL basic_h%0d: got %0d, want 9", i, h_at(i));
            end
        end
    endtask

    task automatic test_single_neuron;
        int dc, nd;
        logic b1;
        set_uniform(3, 0, 0);
        for (int j = 0; j < M; j++) w_h_bus[j*W +: W] = 8'sd2;
        b_h_bus[0 +: W] = -8'sd5;
        do_run(dc, nd, b1);
        tests_run++;
        if (h_at(0) !== 13'sd49) begin
            tests_failed++;
            $display("FAIL single_h0: got %0d, want 49", h_at(0));
        end
        for (int i = 1; i < N; i++) begin
            tests_run++;
            if (h_at(i) !== 13'sd0) begin
                tests_failed++;
                $display("FAIL single_h%0d: got %0d, want 0", i, h_at(i));
            end
        end
    endtask

    task automatic test_saturation;
        int dc, nd;
        logic b1;
        set_uniform(127, 127, 127);
        do_run(dc, nd, b1);
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (h_at(i) !== 13'sd4095) begin
                tests_failed++;
                $display("FAIL sat_pos_h%0d: got %0d, want 4095", i, h_at(i));
            end
        end
        set_uniform(127, -128, 127);
        do_run(dc, nd, b1);
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (h_at(i) !== -13'sd4096) begin
                tests_failed++;
                $display("FAIL sat_neg_h%0d: got %0d, want -4096", i, h_at(i));
            end
        end
    endtask

    task automatic test_input_latch;
        int dc, nd;
        dc = -1;
        nd = 0;
        set_uniform(1, 1, 0);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= LAT + 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                nd++;
                if (dc < 0) dc = c;
            end
            if (c == 10) set_uniform(0, 1, 0);
            if (c == 20) start = 1'b1;
        end
        tests_run++;
        if (dc != 89 || nd != 1) begin
            tests_failed++;
            $display("FAIL latch_done: done at %0d count %0d, want 89 count 1", dc, nd);
        end
        tests_run++;
        if (h_at(0) !== 13'sd9 || h_at(N-1) !== 13'sd9) begin
            tests_failed++;
            $display("FAIL latch_h: h0=%0d h7=%0d, want 9 9", h_at(0), h_at(N-1));
        end
    endtask

    task automatic test_reset_abort;
        int dc, nd;
        logic b1;
        set_uniform(2, 2, 1);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || h_raw_bus !== '0) begin
            tests_failed++;
            $display("FAIL abort_state: busy=%b done=%b h=%h, want 0 0 0", busy, done, h_raw_bus);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < LAT + 5; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        tests_run++;
        if (nd != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: saw %0d done pulses, want 0", nd);
        end
        do_run(dc, nd, b1);
        tests_run++;
        if (dc != 89 || nd != 1) begin
            tests_failed++;
            $display("FAIL abort_rerun: done at %0d count %0d, want 89 count 1", dc, nd);
        end
        tests_run++;
        if (h_at(3) !== 13'sd37) begin
            tests_failed++;
            $display("FAIL abort_rerun_h: got %0d, want 37", h_at(3));
        end
    endtask

    task automatic test_back_to_back;
        int ncyc [$];
        logic [N*HW-1:0] prev;
        int bad_change;
        bad_change = 0;
        set_uniform(1, 1, 0);
        prev = h_raw_bus;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done) begin
                ncyc.push_back(c);
                if (c == 89) begin
                    tests_run++;
                    if (h_at(0) !== 13'sd9 || h_at(N-1) !== 13'sd9) begin
                        tests_failed++;
                        $display("FAIL b2b_h_run1: h0=%0d h7=%0d, want 9 9", h_at(0), h_at(N-1));
                    end
                    set_uniform(3, 1, 0);
                end
                if (c == 179) begin
                    tests_run++;
                    if (h_at(0) !== 13'sd27 || h_at(N-1) !== 13'sd27) begin
                        tests_failed++;
                        $display("FAIL b2b_h_run2: h0=%0d h7=%0d, want 27 27", h_at(0), h_at(N-1));
                    end
                end
            end else if (h_raw_bus !== prev) begin
                bad_change++;
            end
            prev = h_raw_bus;
        end
        start = 1'b0;
        tests_run++;
        if (ncyc.size() != 2 || ncyc[0] != 89 || ncyc[1] != 179) begin
            tests_failed++;
            $display("FAIL b2b_period: %0d pulses, first at %0d, second at %0d, want 2 at 89 and 179",
                     ncyc.size(), (ncyc.size() > 0) ? ncyc[0] : -1, (ncyc.size() > 1) ? ncyc[1] : -1);
        end
        tests_run++;
        if (bad_change != 0) begin
            tests_failed++;
            $display("FAIL b2b_hold: h_raw_bus changed %0d times outside done, want 0", bad_change);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        x_bus   = '0;
        w_h_bus = '0;
        b_h_bus = '0;
        test_reset();
        test_basic();
        test_single_neuron();
        test_saturation();
        test_input_latch();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
